dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_responder_array.sv | 29 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, the
// captured-request record and the address legality check.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // A byte address is illegal when it is not word aligned or when it
   // points beyond the 2**addr_w words that physically exist.
   function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
      logic [31:0] upper;
      upper = addr >> (addr_w + 2);
      return (addr[1:0] != 2'b00) || (upper != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised storage with per-byte write enables. Writes land on the
// rising edge, reads are combinational. Contents are never reset.
module dmem_array #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   // Byte-lane write: only lanes with their enable set are touched.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for a CPU data port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for req; captures the request when it arrives
//   WAIT    | burning wait states, counter counts down to 1
//   RESP    | ack high for one cycle; valid writes commit on this edge
//
// The request is captured on acceptance and only the captured copy is used
// afterwards, so the CPU may change its outputs freely while busy.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy,
   output logic [15:0] wr_count
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT);

   state_t      state;
   state_t      state_nxt;
   req_t        cap;
   logic [3:0]  wait_cnt;
   logic [15:0] wr_count_q;
   logic        accept;
   logic        bad;
   logic        commit;
   logic [31:0] mem_rdata;

   assign accept = (state == ST_IDLE) && req;
   assign bad    = addr_bad(cap.addr, ADDR_W);
   // A reset landing on the RESP edge abandons the write as well.
   assign commit = (state == ST_RESP) && cap.we && !bad && !rst;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = (WAIT == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd1) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request capture, wait-state down-counter and saturating write counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt   <= 4'd0;
         wr_count_q <= 16'd0;
      end else begin
         if (accept) begin
            cap.we    <= we;
            cap.be    <= be;
            cap.addr  <= addr;
            cap.wdata <= wdata;
            wait_cnt  <= WAIT_LD;
         end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (commit && (wr_count_q != WR_COUNT_MAX)) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .wr_en (commit),
      .addr  (cap.addr[ADDR_W+1:2]),
      .be    (cap.be),
      .wdata (cap.wdata),
      .rdata (mem_rdata)
   );

   // Response outputs; rdata is forced to zero outside a valid read ack.
   always_comb begin
      ack   = (state == ST_RESP);
      busy  = (state != ST_IDLE);
      err   = ack && bad;
      rdata = 32'd0;
      if (ack && !bad && !cap.we) begin
         rdata = mem_rdata;
      end
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a WAIT=2 instance for directed functional vectors and a
// WAIT=0 instance for back-to-back streaming with req held high.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req2, we2, ack2, err2, busy2;
   logic [3:0]  be2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [15:0] wcnt2;
   logic        req0, we0, ack0, err0, busy0;
   logic [3:0]  be0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [15:0] wcnt0;
   int          cyc = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [15:0] cnt;
      int          cyc;
   } exp_t;

   exp_t q2[$];
   exp_t q0[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.ADDR_W(8), .WAIT(2)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .we(we2), .be(be2), .addr(addr2),
      .wdata(wdata2), .ack(ack2), .rdata(rdata2), .err(err2), .busy(busy2),
      .wr_count(wcnt2)
   );

   dmem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .be(be0), .addr(addr0),
      .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0),
      .wr_count(wcnt0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event, want none (cycle %0d)", name, cyc);
   endtask

   task automatic monitor();
      exp_t        e;
      logic        pend2 = 1'b0;
      logic        pend0 = 1'b0;
      logic [15:0] pcnt2 = 16'd0;
      logic [15:0] pcnt0 = 16'd0;
      forever begin
         @(negedge clk);
         if (pend2) begin
            chk("wr_count2", 32'(wcnt2), 32'(pcnt2));
            pend2 = 1'b0;
         end
         if (ack2) begin
            if (q2.size() == 0) begin
               fail("unexpected_ack2");
            end else begin
               e = q2.pop_front();
               chk("rdata2", rdata2, e.rdata);
               chk("err2", 32'(err2), 32'(e.err));
               chk("ack_cycle2", 32'(cyc), 32'(e.cyc));
               pend2 = 1'b1;
               pcnt2 = e.cnt;
            end
         end else begin
            chk("idle_rdata2", rdata2, 32'd0);
         end
         if (pend0) begin
            chk("wr_count0", 32'(wcnt0), 32'(pcnt0));
            pend0 = 1'b0;
         end
         if (ack0) begin
            if (q0.size() == 0) begin
               fail("unexpected_ack0");
            end else begin
               e = q0.pop_front();
               chk("rdata0", rdata0, e.rdata);
               chk("err0", 32'(err0), 32'(e.err));
               chk("ack_cycle0", 32'(cyc), 32'(e.cyc));
               pend0 = 1'b1;
               pcnt0 = e.cnt;
            end
         end
      end
   endtask

   task automatic wait_idle2();
      int n = 0;
      @(negedge clk);
      while (busy2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy2) fail("idle_timeout2");
   endtask

   // One request to the WAIT=2 instance; scramble changes all inputs while busy.
   task automatic issue2(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic [15:0] exp_cnt,
                         input logic scramble);
      exp_t e;
      wait_idle2();
      req2 = 1'b1; we2 = w; be2 = b; addr2 = a; wdata2 = d;
      @(posedge clk);
      #1;
      e.rdata = exp_rdata; e.err = exp_err; e.cnt = exp_cnt; e.cyc = cyc + 2;
      q2.push_back(e);
      @(negedge clk);
      if (scramble) begin
         we2 = ~w; be2 = ~b; addr2 = a ^ 32'h4; wdata2 = ~d;
         @(negedge clk);
         @(negedge clk);
      end
      req2 = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   n;
      int   k;
      rst = 1'b1;
      req2 = 0; we2 = 0; be2 = 0; addr2 = 0; wdata2 = 0;
      req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy2", 32'(busy2), 0);
      chk("rst_ack2", 32'(ack2), 0);
      chk("rst_err2", 32'(err2), 0);
      chk("rst_rdata2", rdata2, 0);
      chk("rst_wcnt2", 32'(wcnt2), 0);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_wcnt0", 32'(wcnt0), 0);
      @(negedge clk);
      rst = 1'b0;
      fork
         monitor();
      join_none

      issue2(1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0, 16'd1, 0);

      // Reset while the next write to 0x20 sits in WAIT; req stays high under reset.
      wait_idle2();
      req2 = 1; we2 = 1; be2 = 4'hF; addr2 = 32'h20; wdata2 = 32'hAAAAAAAA;
      @(posedge clk);
      @(negedge clk);
      chk("abort_in_wait2", 32'(busy2), 1);
      rst = 1'b1;
      addr2 = 32'h24;
      @(posedge clk);
      #1;
      chk("abort_busy2", 32'(busy2), 0);
      chk("abort_ack2", 32'(ack2), 0);
      chk("abort_wcnt2", 32'(wcnt2), 0);
      @(negedge clk);
      rst = 1'b0;
      req2 = 1'b0;

      issue2(0, 4'hF, 32'h20, 32'h0,        32'h11223344, 0, 16'd0, 0);
      issue2(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        0, 16'd1, 0);
      issue2(0, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 16'd1, 0);
      issue2(1, 4'h1, 32'h10, 32'h00000055, 32'h0,        0, 16'd2, 0);
      issue2(0, 4'hF, 32'h10, 32'h0,        32'hDEADBE55, 0, 16'd2, 0);
      issue2(1, 4'hF, 32'h12, 32'h12345678, 32'h0,        1, 16'd2, 0);
      issue2(0, 4'hF, 32'h400, 32'h0,       32'h0,        1, 16'd2, 0);
      issue2(0, 4'hF, 32'h80000010, 32'h0,  32'h0,        1, 16'd2, 0);
      issue2(0, 4'hF, 32'h10, 32'h0,        32'hDEADBE55, 0, 16'd2, 0);
      issue2(1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0,        0, 16'd3, 0);
      issue2(0, 4'hF, 32'h10, 32'h0,        32'hDEADBE55, 0, 16'd3, 0);
      issue2(1, 4'hF, 32'h14, 32'h0,        32'h0,        0, 16'd4, 0);
      issue2(1, 4'h6, 32'h14, 32'h12345678, 32'h0,        0, 16'd5, 0);
      issue2(0, 4'hF, 32'h14, 32'h0,        32'h00345600, 0, 16'd5, 0);
      issue2(1, 4'hF, 32'h18, 32'hCAFEF00D, 32'h0,        0, 16'd6, 1);
      issue2(0, 4'hF, 32'h18, 32'h0,        32'hCAFEF00D, 0, 16'd6, 1);

      // Saturation: preload the counter near the top, then keep writing.
      wait_idle2();
      @(negedge clk);
      force dut2.wr_count_q = 16'hFFFC;
      #1;
      release dut2.wr_count_q;
      issue2(1, 4'hF, 32'h1C, 32'h00000001, 32'h0, 0, 16'hFFFD, 0);
      issue2(1, 4'hF, 32'h1C, 32'h00000002, 32'h0, 0, 16'hFFFE, 0);
      issue2(1, 4'hF, 32'h1C, 32'h00000003, 32'h0, 0, 16'hFFFF, 0);
      issue2(1, 4'hF, 32'h1C, 32'h00000004, 32'h0, 0, 16'hFFFF, 0);
      issue2(1, 4'hF, 32'h1E, 32'h00000005, 32'h0, 1, 16'hFFFF, 0);
      issue2(0, 4'hF, 32'h1C, 32'h0,        32'h00000004, 0, 16'hFFFF, 0);

      // WAIT=0 streaming: req never drops; 4 writes then 4 reads back.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("busy_phase0", 32'(busy0), 32'(i % 2));
         req0 = 1'b1;
         if (!busy0) begin
            k = i / 2;
            if (k < 4) begin
               we0 = 1; be0 = 4'hF; addr0 = 32'h40 + 32'(4 * k);
               wdata0 = 32'hA0000000 + 32'(k);
               e.rdata = 32'h0; e.cnt = 16'(k + 1);
            end else begin
               we0 = 0; be0 = 4'hF; addr0 = 32'h40 + 32'(4 * (k - 4));
               wdata0 = 32'h0;
               e.rdata = 32'hA0000000 + 32'(k - 4); e.cnt = 16'd4;
            end
            e.err = 1'b0;
            e.cyc = cyc + 1;
            q0.push_back(e);
         end else begin
            we0 = 1; be0 = 4'hF; addr0 = 32'h44; wdata0 = 32'h5A5A5A5A;
         end
      end
      @(negedge clk);
      req0 = 1'b0;

      n = 0;
      while ((q2.size() != 0 || q0.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q2.size() != 0 || q0.size() != 0) fail("drain_timeout");
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
